// File: rtl/wb_arbiter_pkg.sv
// Shared types and default widths for the writeback arbiter and its source FIFOs.
// Optional feature macro used by wb_arbiter: WB_ROUNDROBIN_EN.
package wb_arbiter_pkg;

    localparam int WB_PREG_W   = 6;
    localparam int WB_ROBINDEX = 6;

    typedef struct packed {
        logic [31:0]            data;
        logic [WB_PREG_W-1:0]   dest;
        logic                   write;
        logic [WB_ROBINDEX-1:0] rob;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    function automatic int wb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding one source's pending writeback entries.
// Pointers wrap modulo DEPTH (power of two); occupancy counter gives empty/full.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_push,
    input  entry_t i_entry,
    input  logic   i_pop,
    output entry_t o_head,
    output logic   o_empty,
    output logic   o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = wb_cnt_w(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];

    // Storage needs no reset: the occupancy counter decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and MEM results and drives one registered write/complete beat per cycle.
// Define WB_ROUNDROBIN_EN for alternating grants under contention; default is fixed MEM priority.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ROBINDEX   = WB_ROBINDEX,
    parameter int PREG_W     = WB_PREG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,

    // valid/ready: a result transfers at a rising edge where X_valid && X_ready;
    // ready depends only on FIFO occupancy and FREEZE, never on valid.
    input  logic                ALU_valid,
    output logic                ALU_ready,
    input  logic [31:0]         ALU_data,
    input  logic [PREG_W-1:0]   ALU_dest,
    input  logic                ALU_write,
    input  logic [ROBINDEX-1:0] ALU_ROBPointer,

    input  logic                MEM_valid,
    output logic                MEM_ready,
    input  logic [31:0]         MEM_data,
    input  logic [PREG_W-1:0]   MEM_dest,
    input  logic                MEM_write,
    input  logic [ROBINDEX-1:0] MEM_ROBPointer,

    output logic [31:0]         write_register_data,
    output logic [PREG_W-1:0]   write_register_index,
    output logic                write_register_flag,
    output logic                Complete_valid,
    output logic [ROBINDEX-1:0] Complete_ROBPointer
);

    typedef struct packed {
        logic [31:0]         data;
        logic [PREG_W-1:0]   dest;
        logic                write;
        logic [ROBINDEX-1:0] rob;
    } entry_t;

    entry_t  w_alu_in;
    entry_t  w_mem_in;
    entry_t  w_alu_head;
    entry_t  w_mem_head;
    entry_t  w_head;
    logic    w_alu_empty;
    logic    w_alu_full;
    logic    w_mem_empty;
    logic    w_mem_full;
    logic    w_alu_push;
    logic    w_mem_push;
    logic    w_alu_pop;
    logic    w_mem_pop;
    logic    w_grant_any;
    wb_src_e w_grant_src;

    logic [31:0]         r_data;
    logic [PREG_W-1:0]   r_index;
    logic                r_flag;
    logic                r_cvalid;
    logic [ROBINDEX-1:0] r_rob;

    assign w_alu_in = '{data: ALU_data, dest: ALU_dest, write: ALU_write, rob: ALU_ROBPointer};
    assign w_mem_in = '{data: MEM_data, dest: MEM_dest, write: MEM_write, rob: MEM_ROBPointer};

    // A full FIFO refuses even when it pops this cycle, keeping ready a pure occupancy function.
    assign ALU_ready  = !w_alu_full && !FREEZE;
    assign MEM_ready  = !w_mem_full && !FREEZE;
    assign w_alu_push = ALU_valid && ALU_ready;
    assign w_mem_push = MEM_valid && MEM_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_alu_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_alu_push),
        .i_entry (w_alu_in),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_empty (w_alu_empty),
        .o_full  (w_alu_full)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_mem_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_mem_push),
        .i_entry (w_mem_in),
        .i_pop   (w_mem_pop),
        .o_head  (w_mem_head),
        .o_empty (w_mem_empty),
        .o_full  (w_mem_full)
    );

`ifdef WB_ROUNDROBIN_EN
    wb_src_e r_last_grant;
`endif

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_src = WB_SRC_MEM;
        if (!FREEZE) begin
            if (!w_alu_empty && !w_mem_empty) begin
                w_grant_any = 1'b1;
`ifdef WB_ROUNDROBIN_EN
                w_grant_src = (r_last_grant == WB_SRC_MEM) ? WB_SRC_ALU : WB_SRC_MEM;
`else
                w_grant_src = WB_SRC_MEM;
`endif
            end else if (!w_mem_empty) begin
                w_grant_any = 1'b1;
                w_grant_src = WB_SRC_MEM;
            end else if (!w_alu_empty) begin
                w_grant_any = 1'b1;
                w_grant_src = WB_SRC_ALU;
            end
        end
    end

    assign w_head    = (w_grant_src == WB_SRC_MEM) ? w_mem_head : w_alu_head;
    assign w_alu_pop = w_grant_any && (w_grant_src == WB_SRC_ALU);
    assign w_mem_pop = w_grant_any && (w_grant_src == WB_SRC_MEM);

`ifdef WB_ROUNDROBIN_EN
    // Resetting to ALU makes MEM the winner of the first contention.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_last_grant <= WB_SRC_ALU;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_src;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data   <= '0;
            r_index  <= '0;
            r_flag   <= 1'b0;
            r_cvalid <= 1'b0;
            r_rob    <= '0;
        end else if (w_grant_any) begin
            r_data   <= w_head.data;
            r_index  <= w_head.dest;
            r_flag   <= w_head.write;
            r_cvalid <= 1'b1;
            r_rob    <= w_head.rob;
        end else begin
            r_flag   <= 1'b0;
            r_cvalid <= 1'b0;
        end
    end

    assign write_register_data  = r_data;
    assign write_register_index = r_index;
    assign write_register_flag  = r_flag;
    assign Complete_valid       = r_cvalid;
    assign Complete_ROBPointer  = r_rob;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single results, contention/full, freeze, wrap, mid-burst reset.
module tb_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FREEZE = 1'b0;
    logic        ALU_valid = 1'b0;
    logic        ALU_ready;
    logic [31:0] ALU_data = '0;
    logic [5:0]  ALU_dest = '0;
    logic        ALU_write = 1'b0;
    logic [5:0]  ALU_ROBPointer = '0;
    logic        MEM_valid = 1'b0;
    logic        MEM_ready;
    logic [31:0] MEM_data = '0;
    logic [5:0]  MEM_dest = '0;
    logic        MEM_write = 1'b0;
    logic [5:0]  MEM_ROBPointer = '0;
    logic [31:0] write_register_data;
    logic [5:0]  write_register_index;
    logic        write_register_flag;
    logic        Complete_valid;
    logic [5:0]  Complete_ROBPointer;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    wb_arbiter #(.ROBINDEX(6), .PREG_W(6), .FIFO_DEPTH(2)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .FREEZE               (FREEZE),
        .ALU_valid            (ALU_valid),
        .ALU_ready            (ALU_ready),
        .ALU_data             (ALU_data),
        .ALU_dest             (ALU_dest),
        .ALU_write            (ALU_write),
        .ALU_ROBPointer       (ALU_ROBPointer),
        .MEM_valid            (MEM_valid),
        .MEM_ready            (MEM_ready),
        .MEM_data             (MEM_data),
        .MEM_dest             (MEM_dest),
        .MEM_write            (MEM_write),
        .MEM_ROBPointer       (MEM_ROBPointer),
        .write_register_data  (write_register_data),
        .write_register_index (write_register_index),
        .write_register_flag  (write_register_flag),
        .Complete_valid       (Complete_valid),
        .Complete_ROBPointer  (Complete_ROBPointer)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        ALU_valid = 1'b0;
        MEM_valid = 1'b0;
        FREEZE    = 1'b0;
        RESET     = 1'b0;
        tick();
        @(negedge CLK);
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RESET     = 1'b0;
        ALU_valid = 1'b1;
        ALU_data  = 32'h1111_1111;
        ALU_write = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({write_register_data, write_register_index, write_register_flag, Complete_valid, Complete_ROBPointer} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got data=%h idx=%0d flag=%b cv=%b rob=%0d required all 0",
                     write_register_data, write_register_index, write_register_flag, Complete_valid, Complete_ROBPointer);
        end
        n_vec++;
        if ({ALU_ready, MEM_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_ready got alu=%b mem=%b required 1 1", ALU_ready, MEM_ready);
        end
        ALU_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({write_register_flag, Complete_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_no_write cyc=%0d got flag=%b cv=%b required 0 0", k, write_register_flag, Complete_valid);
            end
        end
    endtask

    task automatic test_single_alu();
        ALU_valid      = 1'b1;
        ALU_data       = 32'hDEAD_BEEF;
        ALU_dest       = 6'd5;
        ALU_write      = 1'b1;
        ALU_ROBPointer = 6'd3;
        tick();
        ALU_valid = 1'b0;
        n_vec++;
        if (Complete_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency got cv=%b required 0", Complete_valid);
        end
        tick();
        n_vec++;
        if ({write_register_flag, Complete_valid, write_register_index, write_register_data, Complete_ROBPointer}
            !== {1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF, 6'd3}) begin
            n_err++;
            $display("FAIL single_beat got flag=%b cv=%b idx=%0d data=%h rob=%0d required 1 1 5 deadbeef 3",
                     write_register_flag, Complete_valid, write_register_index, write_register_data, Complete_ROBPointer);
        end
        tick();
        n_vec++;
        if ({write_register_flag, Complete_valid, write_register_data} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL single_one_cycle got flag=%b cv=%b data=%h required 0 0 deadbeef",
                     write_register_flag, Complete_valid, write_register_data);
        end
    endtask

    task automatic test_store_mem();
        MEM_valid      = 1'b1;
        MEM_data       = 32'h0000_1234;
        MEM_dest       = 6'd9;
        MEM_write      = 1'b0;
        MEM_ROBPointer = 6'd7;
        tick();
        MEM_valid = 1'b0;
        tick();
        n_vec++;
        if ({Complete_valid, Complete_ROBPointer, write_register_flag, write_register_data}
            !== {1'b1, 6'd7, 1'b0, 32'h0000_1234}) begin
            n_err++;
            $display("FAIL store_beat got cv=%b rob=%0d flag=%b data=%h required 1 7 0 00001234",
                     Complete_valid, Complete_ROBPointer, write_register_flag, write_register_data);
        end
        tick();
        n_vec++;
        if (Complete_valid !== 1'b0) begin
            n_err++;
            $display("FAIL store_one_cycle got cv=%b required 0", Complete_valid);
        end
    endtask

    // Both sources present a new value every cycle for 4 edges; refused values must never appear.
    task automatic test_contention();
        logic        exp_cv   [8];
        logic [5:0]  exp_rob  [8];
        logic [31:0] exp_data [8];
        logic        exp_ardy [8];
        apply_reset();
        exp_cv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef WB_ROUNDROBIN_EN
        exp_rob  = '{6'd0, 6'd2, 6'd1, 6'd2, 6'd1, 6'd2, 6'd1, 6'd0};
        exp_data = '{32'h0, 32'hB000_0000, 32'hA000_0000, 32'hB000_0001, 32'hA000_0001,
                     32'hB000_0002, 32'hA000_0003, 32'h0};
        exp_ardy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_rob  = '{6'd0, 6'd2, 6'd2, 6'd2, 6'd2, 6'd1, 6'd1, 6'd0};
        exp_data = '{32'h0, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
                     32'hA000_0000, 32'hA000_0001, 32'h0};
        exp_ardy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        ALU_dest = 6'd1; ALU_write = 1'b1; ALU_ROBPointer = 6'd1;
        MEM_dest = 6'd2; MEM_write = 1'b1; MEM_ROBPointer = 6'd2;
        for (int k = 0; k < 8; k++) begin
            ALU_valid = (k < 4);
            MEM_valid = (k < 4);
            ALU_data  = 32'hA000_0000 + 32'(k);
            MEM_data  = 32'hB000_0000 + 32'(k);
            tick();
            n_vec++;
            if (Complete_valid !== exp_cv[k]) begin
                n_err++;
                $display("FAIL contention_cv edge=%0d got %b required %b", k + 1, Complete_valid, exp_cv[k]);
            end
            if (exp_cv[k]) begin
                n_vec++;
                if ({Complete_ROBPointer, write_register_data} !== {exp_rob[k], exp_data[k]}) begin
                    n_err++;
                    $display("FAIL contention_order edge=%0d got rob=%0d data=%h required rob=%0d data=%h",
                             k + 1, Complete_ROBPointer, write_register_data, exp_rob[k], exp_data[k]);
                end
            end
            n_vec++;
            if (ALU_ready !== exp_ardy[k]) begin
                n_err++;
                $display("FAIL contention_alu_ready edge=%0d got %b required %b", k + 1, ALU_ready, exp_ardy[k]);
            end
        end
    endtask

    task automatic test_freeze();
        ALU_valid = 1'b1; ALU_data = 32'hC0; ALU_dest = 6'd10; ALU_write = 1'b1; ALU_ROBPointer = 6'd4;
        tick();
        FREEZE = 1'b1;
        ALU_data = 32'hC9; ALU_ROBPointer = 6'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if ({ALU_ready, MEM_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL freeze_ready cyc=%0d got alu=%b mem=%b required 0 0", k, ALU_ready, MEM_ready);
            end
            tick();
            n_vec++;
            if ({write_register_flag, Complete_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL freeze_no_write cyc=%0d got flag=%b cv=%b required 0 0", k, write_register_flag, Complete_valid);
            end
        end
        FREEZE = 1'b0;
        ALU_data = 32'hC1; ALU_ROBPointer = 6'd5;
        tick();
        ALU_valid = 1'b0;
        n_vec++;
        if ({Complete_valid, Complete_ROBPointer, write_register_data} !== {1'b1, 6'd4, 32'hC0}) begin
            n_err++;
            $display("FAIL freeze_drain0 got cv=%b rob=%0d data=%h required 1 4 000000c0",
                     Complete_valid, Complete_ROBPointer, write_register_data);
        end
        tick();
        n_vec++;
        if ({Complete_valid, Complete_ROBPointer, write_register_data} !== {1'b1, 6'd5, 32'hC1}) begin
            n_err++;
            $display("FAIL freeze_drain1 got cv=%b rob=%0d data=%h required 1 5 000000c1",
                     Complete_valid, Complete_ROBPointer, write_register_data);
        end
        tick();
        n_vec++;
        if (Complete_valid !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_drain_end got cv=%b required 0", Complete_valid);
        end
    endtask

    // Six back-to-back ALU results wrap the depth-2 pointers three times; dest 0 is ordinary.
    task automatic test_wrap();
        logic [31:0] exp_d;
        ALU_write = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ALU_valid      = (k < 6);
            ALU_data       = 32'hE0 + 32'(k);
            ALU_dest       = 6'(k);
            ALU_ROBPointer = 6'(k + 10);
            tick();
            if (k > 0) begin
                exp_d = 32'hE0 + 32'(k - 1);
                n_vec++;
                if ({write_register_flag, Complete_valid, write_register_data, write_register_index, Complete_ROBPointer}
                    !== {1'b1, 1'b1, exp_d, 6'(k - 1), 6'(k + 9)}) begin
                    n_err++;
                    $display("FAIL wrap_seq k=%0d got flag=%b cv=%b data=%h idx=%0d rob=%0d required 1 1 %h %0d %0d",
                             k, write_register_flag, Complete_valid, write_register_data, write_register_index,
                             Complete_ROBPointer, exp_d, k - 1, k + 9);
                end
            end
        end
        tick();
        n_vec++;
        if (Complete_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_end got cv=%b required 0", Complete_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        ALU_valid = 1'b1; ALU_data = 32'h5A5A_0001; ALU_write = 1'b1; ALU_dest = 6'd3; ALU_ROBPointer = 6'd6;
        MEM_valid = 1'b1; MEM_data = 32'h5A5A_0002; MEM_write = 1'b1; MEM_dest = 6'd4; MEM_ROBPointer = 6'd8;
        tick();
        tick();
        #2;
        RESET = 1'b0;
        #1;
        n_vec++;
        if ({write_register_data, write_register_index, write_register_flag, Complete_valid, Complete_ROBPointer} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got data=%h idx=%0d flag=%b cv=%b rob=%0d required all 0",
                     write_register_data, write_register_index, write_register_flag, Complete_valid, Complete_ROBPointer);
        end
        ALU_valid = 1'b0;
        MEM_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_vec++;
        if ({ALU_ready, MEM_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL midreset_ready got alu=%b mem=%b required 1 1", ALU_ready, MEM_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({write_register_flag, Complete_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL midreset_stale cyc=%0d got flag=%b cv=%b required 0 0", k, write_register_flag, Complete_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_store_mem();
        test_contention();
        test_freeze();
        test_wrap();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
